// File: rtl/counter_sequencer.sv
// Run controller for an external up-counter: arms it, paces increments through a
// prescaler, detects the programmed terminal count and handles pause/stop/auto-reload.
module counter_sequencer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  pause_i,
    input  logic                  repeat_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic [PRESCALE_W-1:0] div_i,
    input  logic [WIDTH-1:0]      cnt_val_i,
    output logic                  cnt_en_o,
    output logic                  cnt_clr_o,
    output logic                  busy_o,
    output logic                  paused_o,
    output logic                  done_o,
    output logic [7:0]            loops_o
);

    localparam logic [7:0] LOOPS_MAX = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] div_q;
    logic [WIDTH-1:0]      limit_q;
    logic                  repeat_q;
    logic [7:0]            loops_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  paused_q;

    logic tick;
    logic terminal;
    logic start_acc;
    logic term_evt;

    // A start arriving during the single ARM cycle is ignored; stop always wins.
    assign tick      = (state_q == S_RUN) && (presc_q == div_q);
    assign terminal  = tick && (cnt_val_i == limit_q);
    assign start_acc = start_i && !stop_i && (state_q != S_ARM);
    assign term_evt  = terminal && !stop_i && !start_acc;

    // Counter controls decode from current state, prescaler and counter value only.
    always_comb begin
        cnt_en_o  = tick && !terminal;
        cnt_clr_o = (state_q == S_ARM) || (terminal && repeat_q);
    end

    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = S_IDLE;
        end else if (start_acc) begin
            state_d = S_ARM;
        end else begin
            case (state_q)
                S_ARM:   state_d = pause_i ? S_PAUSE : S_RUN;
                S_RUN: begin
                    if (terminal && !repeat_q) begin
                        state_d = S_DONE;
                    end else if (pause_i) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!pause_i) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Prescaler restarts when arming, wraps on tick, and is frozen outside RUN.
    always_comb begin
        presc_d = presc_q;
        case (state_q)
            S_ARM:   presc_d = '0;
            S_RUN:   presc_d = tick ? '0 : presc_q + 1'b1;
            default: presc_d = presc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            div_q    <= '0;
            limit_q  <= '0;
            repeat_q <= 1'b0;
            loops_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            busy_q   <= (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_PAUSE);
            paused_q <= (state_d == S_PAUSE);
            done_q   <= term_evt;
            if (start_acc) begin
                limit_q  <= limit_i;
                div_q    <= div_i;
                repeat_q <= repeat_i;
                loops_q  <= '0;
            end else if (term_evt && (loops_q != LOOPS_MAX)) begin
                loops_q <= loops_q + 1'b1;
            end
        end
    end

    assign busy_o   = busy_q;
    assign paused_o = paused_q;
    assign done_o   = done_q;
    assign loops_o  = loops_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: models the attached counter and predicts every output
// from run-length arithmetic (active cycles, period, terminal count).
module tb_counter_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_FIN   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, stop_i, pause_i, repeat_i;
    logic [3:0] limit_i;
    logic [7:0] div_i;
    logic [3:0] cnt;
    logic       cnt_en_o, cnt_clr_o, busy_o, paused_o, done_o;
    logic [7:0] loops_o;

    int checks = 0;
    int errors = 0;

    // Reference: mode, latched config, active RUN cycles since arming, terminal count.
    int m_mode, m_lim, m_div, m_act, m_terms, m_hold;
    bit m_rep, m_done;

    always #5 clk = ~clk;

    // The counter datapath being controlled.
    always @(posedge clk or posedge rst) begin
        if (rst)            cnt <= 4'd0;
        else if (cnt_clr_o) cnt <= 4'd0;
        else if (cnt_en_o)  cnt <= cnt + 4'd1;
    end

    counter_sequencer #(.WIDTH(4), .PRESCALE_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .pause_i  (pause_i),
        .repeat_i (repeat_i),
        .limit_i  (limit_i),
        .div_i    (div_i),
        .cnt_val_i(cnt),
        .cnt_en_o (cnt_en_o),
        .cnt_clr_o(cnt_clr_o),
        .busy_o   (busy_o),
        .paused_o (paused_o),
        .done_o   (done_o),
        .loops_o  (loops_o)
    );

    function automatic logic [16:0] dut_vec();
        return {cnt_en_o, cnt_clr_o, busy_o, paused_o, done_o, loops_o, cnt};
    endfunction

    function automatic logic [16:0] exp_vec();
        int   p, ph, cv;
        logic en, clr, bz, pz;
        p  = (m_lim + 1) * (m_div + 1);
        ph = m_act % p;
        en = 1'b0; clr = 1'b0; bz = 1'b0; pz = 1'b0; cv = m_hold;
        case (m_mode)
            M_ARM: begin clr = 1'b1; bz = 1'b1; end
            M_RUN: begin
                bz  = 1'b1;
                cv  = ph / (m_div + 1);
                en  = ((ph % (m_div + 1)) == m_div) && (ph != p - 1);
                clr = (ph == p - 1) && m_rep;
            end
            M_PAUSE: begin bz = 1'b1; pz = 1'b1; cv = ph / (m_div + 1); end
            default: ;
        endcase
        return {en, clr, bz, pz, m_done, 8'(m_terms > 255 ? 255 : m_terms), 4'(cv)};
    endfunction

    function automatic bit m_terminal();
        int p;
        p = (m_lim + 1) * (m_div + 1);
        return (m_mode == M_RUN) && ((m_act % p) == p - 1);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_lim = 0; m_div = 0; m_rep = 1'b0;
        m_act = 0; m_terms = 0; m_hold = 0; m_done = 1'b0;
    endtask

    // Advance the reference by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        int p, ph, nxt;
        bit term;
        p    = (m_lim + 1) * (m_div + 1);
        ph   = m_act % p;
        term = m_terminal();
        case (m_mode)
            M_ARM:   nxt = 0;
            M_RUN:   nxt = (term && !m_rep) ? m_lim : ((ph + 1) % p) / (m_div + 1);
            M_PAUSE: nxt = ph / (m_div + 1);
            default: nxt = m_hold;
        endcase
        m_done = 1'b0;
        if (stop_i) begin
            m_hold = nxt; m_mode = M_IDLE;
        end else if (start_i && m_mode != M_ARM) begin
            m_hold = nxt; m_mode = M_ARM; m_terms = 0;
            m_lim = int'(limit_i); m_div = int'(div_i); m_rep = repeat_i;
        end else begin
            case (m_mode)
                M_ARM: begin m_act = 0; m_mode = pause_i ? M_PAUSE : M_RUN; end
                M_RUN: begin
                    if (term) begin m_terms++; m_done = 1'b1; end
                    if (term && !m_rep) begin
                        m_hold = nxt; m_mode = M_FIN;
                    end else begin
                        m_act++;
                        if (pause_i) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (!pause_i) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
        end
        adv();
        checks++;
        if (busy_o !== 1'b0 || loops_o !== 8'd0 || done_o !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy=%b loops=%0d done=%b exp 0/0/0", busy_o, loops_o, done_o);
        end
    endtask

    task automatic test_single();
        int first = -1;
        limit_i = 4'd3; div_i = 8'd0; repeat_i = 1'b0; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL single k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (done_o && first < 0) first = k;
            adv();
        end
        checks++;
        if (first !== 5) begin errors++; $display("FAIL single_done_at got=S+%0d exp=S+5", first); end
        checks++;
        if (cnt !== 4'd3 || busy_o !== 1'b0 || cnt_en_o !== 1'b0) begin
            errors++; $display("FAIL single_end cnt=%0d busy=%b en=%b exp 3/0/0", cnt, busy_o, cnt_en_o);
        end
    endtask

    task automatic test_prescale();
        int first = -1;
        limit_i = 4'd2; div_i = 8'd2; repeat_i = 1'b0; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k < 14; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL prescale k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (done_o && first < 0) first = k;
            adv();
        end
        checks++;
        if (first !== 10 || loops_o !== 8'd1) begin
            errors++; $display("FAIL prescale_done got=S+%0d loops=%0d exp S+10 loops=1", first, loops_o);
        end
    endtask

    task automatic test_repeat();
        int pulses = 0;
        limit_i = 4'd1; div_i = 8'd0; repeat_i = 1'b1; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL repeat k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (done_o) pulses++;
            stop_i = (k == 7);
            adv();
        end
        stop_i = 1'b0;
        checks++;
        if (pulses !== 3 || loops_o !== 8'd3 || busy_o !== 1'b0 || cnt_en_o !== 1'b0 || cnt !== 4'd1) begin
            errors++;
            $display("FAIL repeat_stop pulses=%0d loops=%0d busy=%b en=%b cnt=%0d exp 3/3/0/0/1",
                     pulses, loops_o, busy_o, cnt_en_o, cnt);
        end
        adv(); adv();
        checks++;
        if (dut_vec() !== exp_vec() || cnt !== 4'd1) begin
            errors++; $display("FAIL repeat_hold got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_pause();
        int first = -1;
        limit_i = 4'd5; div_i = 8'd0; repeat_i = 1'b0; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pause_i = (k >= 2 && k <= 6);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL pause k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k == 5) begin
                checks++;
                if (paused_o !== 1'b1 || cnt !== 4'd2 || cnt_en_o !== 1'b0) begin
                    errors++; $display("FAIL pause_hold paused=%b cnt=%0d en=%b exp 1/2/0", paused_o, cnt, cnt_en_o);
                end
            end
            if (done_o && first < 0) first = k;
            adv();
        end
        pause_i = 1'b0;
        checks++;
        if (first !== 12) begin errors++; $display("FAIL pause_done_at got=S+%0d exp=S+12", first); end
    endtask

    task automatic test_start_stop();
        limit_i = 4'd3; div_i = 8'd0; repeat_i = 1'b0; start_i = 1'b1; stop_i = 1'b1;
        adv();
        start_i = 1'b0; stop_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || cnt_clr_o !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL start_stop_same got=%h exp=%h", dut_vec(), exp_vec());
        end
        limit_i = 4'd5; repeat_i = 1'b1; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL restart k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            start_i = (k == 10);
            adv();
        end
        start_i = 1'b0;
        checks++;
        if (cnt_clr_o !== 1'b1 || loops_o !== 8'd0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL restart_arm clr=%b loops=%0d busy=%b exp 1/0/1", cnt_clr_o, loops_o, busy_o);
        end
        adv();
        checks++;
        if (cnt !== 4'd0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL restart_zero cnt=%0d got=%h exp=%h", cnt, dut_vec(), exp_vec());
        end
        stop_i = 1'b1;
        adv();
        stop_i = 1'b0;
    endtask

    task automatic test_async_reset();
        int first = -1;
        limit_i = 4'd9; div_i = 8'd1; repeat_i = 1'b0; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k < 6; k++) adv();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 17'h0) begin
            errors++; $display("FAIL async_reset got=%h exp=00000", dut_vec());
        end
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        limit_i = 4'd0; div_i = 8'd0; start_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (done_o && first < 0) first = k;
            adv();
        end
        checks++;
        if (first !== 2) begin errors++; $display("FAIL limit0_done_at got=S+%0d exp=S+2", first); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) pause_i = ~pause_i;
            start_i  = (m_mode == M_IDLE || m_mode == M_FIN) ? ($urandom_range(0, 3) == 0)
                                                             : ($urandom_range(0, 39) == 0);
            if (m_mode == M_ARM || m_terminal()) start_i = 1'b0;
            stop_i   = ($urandom_range(0, 59) == 0) && !m_terminal();
            limit_i  = 4'($urandom_range(0, 15));
            div_i    = 8'($urandom_range(0, 3));
            repeat_i = 1'($urandom_range(0, 1));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
            end
            adv();
        end
        start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; repeat_i = 1'b0;
        limit_i = 4'd0; div_i = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single();
        test_prescale();
        test_repeat();
        test_pause();
        test_start_stop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
